// File: rtl/usb_inject_tx.sv
// usb_inject_tx: drains host-written OUT packets (8-byte big-endian meta header plus
// payload) from the USB endpoint buffer into the TX data and meta FIFOs, then re-arms the buffer.
module usb_inject_tx #(
   parameter int HDR_LEN = 8,
   parameter int MAX_LEN = 512
) (
   input  logic        clock,
   input  logic        reset,
   output logic [8:0]  usb_out_addr,
   input  logic [7:0]  usb_out_data,
   input  logic        usb_out_ready,
   input  logic [9:0]  usb_out_len,
   output logic        usb_out_arm,
   input  logic        usb_out_arm_ack,
   output logic [63:0] meta,
   output logic [9:0]  meta_len,
   output logic        meta_wren,
   input  logic        meta_full,
   output logic [7:0]  data,
   output logic        data_wren,
   output logic        data_last,
   input  logic        data_full,
   output logic        error
);

   typedef enum logic [2:0] {
      IDLE, CHECK, META_RD, DATA_RD, DRAIN, META_WR, RELEASE, WAIT
   } state_t;

   localparam logic [9:0] HDR_L     = 10'(HDR_LEN);
   localparam logic [9:0] MAX_L     = 10'(MAX_LEN);
   localparam logic [8:0] HDR_LAST  = 9'(HDR_LEN - 1);

   state_t      state_q, state_d;
   logic [9:0]  len_q, len_d;
   logic [8:0]  addr_d;
   logic        rd_vld_q, rd_vld_d;
   logic        rd_meta_q, rd_meta_d;
   logic        rd_last_q, rd_last_d;
   logic [63:0] meta_d;
   logic [9:0]  meta_len_d;
   logic [7:0]  data_d;
   logic        data_wren_d, data_last_d, meta_wren_d, error_d, arm_d;
   logic        addr_is_last;

   assign addr_is_last = ({1'b0, usb_out_addr} == (len_q - 10'd1));

   // Next-state and next-output logic. The rd_* flags tag the read issued last cycle,
   // so its returning byte is captured whatever state the FSM has moved on to.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      addr_d      = usb_out_addr;
      rd_vld_d    = 1'b0;
      rd_meta_d   = 1'b0;
      rd_last_d   = 1'b0;
      meta_d      = meta;
      meta_len_d  = meta_len;
      data_d      = data;
      data_wren_d = 1'b0;
      data_last_d = 1'b0;
      meta_wren_d = 1'b0;
      error_d     = 1'b0;
      arm_d       = 1'b0;

      if (rd_vld_q) begin
         if (rd_meta_q) begin
            meta_d = {meta[55:0], usb_out_data};
         end else begin
            data_d      = usb_out_data;
            data_wren_d = 1'b1;
            data_last_d = rd_last_q;
         end
      end

      case (state_q)
         IDLE: begin
            if (usb_out_ready && !meta_full) begin
               len_d   = usb_out_len;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if ((len_q < HDR_L) || (len_q > MAX_L)) begin
               error_d = 1'b1;
               state_d = RELEASE;
            end else begin
               addr_d     = '0;
               meta_len_d = len_q - HDR_L;
               state_d    = META_RD;
            end
         end
         META_RD: begin
            rd_vld_d  = 1'b1;
            rd_meta_d = 1'b1;
            if (usb_out_addr == HDR_LAST) begin
               if (len_q == HDR_L) begin
                  state_d = DRAIN;
               end else begin
                  addr_d  = usb_out_addr + 9'd1;
                  state_d = DATA_RD;
               end
            end else begin
               addr_d = usb_out_addr + 9'd1;
            end
         end
         DATA_RD: begin
            // The address only advances when the data FIFO has room; the final
            // address is held rather than incremented so it can never wrap.
            if (!data_full) begin
               rd_vld_d  = 1'b1;
               rd_last_d = addr_is_last;
               if (addr_is_last) begin
                  state_d = DRAIN;
               end else begin
                  addr_d = usb_out_addr + 9'd1;
               end
            end
         end
         DRAIN: begin
            state_d = META_WR;
         end
         META_WR: begin
            if (!meta_full) begin
               meta_wren_d = 1'b1;
               state_d     = RELEASE;
            end
         end
         RELEASE: begin
            arm_d = !usb_out_arm_ack;
            if (usb_out_arm_ack) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (!usb_out_arm_ack) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // All outputs are registered so a synchronous reset clears them on the next edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         len_q        <= '0;
         usb_out_addr <= '0;
         rd_vld_q     <= 1'b0;
         rd_meta_q    <= 1'b0;
         rd_last_q    <= 1'b0;
         meta         <= '0;
         meta_len     <= '0;
         data         <= '0;
         data_wren    <= 1'b0;
         data_last    <= 1'b0;
         meta_wren    <= 1'b0;
         error        <= 1'b0;
         usb_out_arm  <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         usb_out_addr <= addr_d;
         rd_vld_q     <= rd_vld_d;
         rd_meta_q    <= rd_meta_d;
         rd_last_q    <= rd_last_d;
         meta         <= meta_d;
         meta_len     <= meta_len_d;
         data         <= data_d;
         data_wren    <= data_wren_d;
         data_last    <= data_last_d;
         meta_wren    <= meta_wren_d;
         error        <= error_d;
         usb_out_arm  <= arm_d;
      end
   end

endmodule

// File: tb/tb_usb_inject_tx.sv
// tb_usb_inject_tx: randomized self-checking bench for usb_inject_tx, compared against
// a packet-level model built directly from the endpoint buffer contents.
module tb_usb_inject_tx;

   logic        clock = 1'b0;
   logic        reset;
   logic [8:0]  usb_out_addr;
   logic [7:0]  usb_out_data;
   logic        usb_out_ready;
   logic [9:0]  usb_out_len;
   logic        usb_out_arm;
   logic        usb_out_arm_ack;
   logic [63:0] meta;
   logic [9:0]  meta_len;
   logic        meta_wren;
   logic        meta_full;
   logic [7:0]  data;
   logic        data_wren;
   logic        data_last;
   logic        data_full;
   logic        error;

   usb_inject_tx dut (
      .clock(clock), .reset(reset),
      .usb_out_addr(usb_out_addr), .usb_out_data(usb_out_data),
      .usb_out_ready(usb_out_ready), .usb_out_len(usb_out_len),
      .usb_out_arm(usb_out_arm), .usb_out_arm_ack(usb_out_arm_ack),
      .meta(meta), .meta_len(meta_len), .meta_wren(meta_wren), .meta_full(meta_full),
      .data(data), .data_wren(data_wren), .data_last(data_last), .data_full(data_full),
      .error(error)
   );

   always #5 clock = ~clock;

   // Endpoint buffer: read data appears one cycle after the address.
   logic [7:0] ep_buf [512];
   always @(posedge clock) usb_out_data <= ep_buf[usb_out_addr];

   int errors = 0;
   int checks = 0;

   logic [7:0]  got_data [$];
   int          meta_cnt, err_cnt, first_cyc, last_cyc, meta_cyc, max_addr;
   int          hold_chk, hold_viol, n_last, last_idx;
   bit          zero_seen, arm_seen, timed_out, rst_done;
   logic [63:0] meta_got;
   logic [9:0]  meta_len_got;
   logic [8:0]  addr_hist [4];
   logic [95:0] rst_snap;

   logic [7:0]  exp_data [$];
   logic [63:0] exp_meta;
   logic [9:0]  exp_meta_len;
   bit          exp_drop;

   // Reference model: header bytes 0..7 form the meta word, bytes 8..len-1 are payload.
   task automatic build_model(input int len);
      exp_drop = (len < 8) || (len > 512);
      exp_meta = '0;
      exp_data.delete();
      for (int i = 0; i < 8; i++) exp_meta[63 - 8*i -: 8] = ep_buf[i];
      exp_meta_len = exp_drop ? 10'd0 : 10'(len - 8);
      if (!exp_drop) for (int i = 8; i < len; i++) exp_data.push_back(ep_buf[i]);
   endtask

   function automatic int payload_diffs();
      int n;
      n = (got_data.size() > exp_data.size()) ? got_data.size() - exp_data.size()
                                              : exp_data.size() - got_data.size();
      for (int i = 0; i < got_data.size() && i < exp_data.size(); i++)
         if (got_data[i] !== exp_data[i]) n++;
      return n;
   endfunction

   // Presents one packet, plays the host side of the arm/ack handshake, applies
   // backpressure and records everything the DUT writes. abort_at>0 pulses reset
   // after that many payload bytes and then lets the packet be processed again.
   task automatic run_packet(input int len, input int stall_at, input int stall_cyc,
                             input int mfull_cyc, input bit rnd_bp, input int abort_at);
      int         stall_left, mfull_left, settle, budget, base, rel;
      bit         prev_full, aborted, data_seen;
      logic [8:0] prev_addr;
      got_data.delete();
      meta_cnt = 0; err_cnt = 0; first_cyc = -1; last_cyc = -1; meta_cyc = -1;
      max_addr = 0; hold_chk = 0; hold_viol = 0; n_last = 0; last_idx = -1;
      zero_seen = 0; arm_seen = 0; timed_out = 1; rst_done = 0;
      rst_snap = '1; meta_got = '0; meta_len_got = '0;
      for (int i = 0; i < 4; i++) addr_hist[i] = '1;
      stall_left = 0; mfull_left = 0; settle = -1; base = 0;
      prev_full = 0; aborted = 0; data_seen = 0; prev_addr = usb_out_addr;
      budget = 4*len + 300;
      usb_out_len = 10'(len);
      usb_out_ready = 1'b1;
      for (int cyc = 0; cyc < budget; cyc++) begin
         @(negedge clock);
         if (aborted && !rst_done) begin
            rst_snap = {usb_out_addr, meta, meta_len, meta_wren, data, data_wren,
                        data_last, error, usb_out_arm};
            rst_done = 1; reset = 1'b0; base = cyc + 1;
            got_data.delete();
            meta_cnt = 0; err_cnt = 0; first_cyc = -1; last_cyc = -1; meta_cyc = -1;
            n_last = 0; last_idx = -1; data_seen = 0; prev_full = 0;
            prev_addr = usb_out_addr;
            continue;
         end
         rel = cyc - base;
         if (rel >= 0 && rel < 4) addr_hist[rel] = usb_out_addr;
         if (usb_out_addr == 9'd0) zero_seen = 1;
         if (zero_seen && int'(usb_out_addr) > max_addr) max_addr = int'(usb_out_addr);
         if (prev_full) begin
            hold_chk++;
            if (usb_out_addr !== prev_addr) hold_viol++;
         end
         if (data_last) begin
            n_last++;
            last_idx = data_wren ? got_data.size() : -2;
         end
         if (data_wren) begin
            got_data.push_back(data);
            if (first_cyc < 0) first_cyc = rel;
            if (data_last) last_cyc = rel;
            data_seen = 1;
         end
         if (meta_wren) begin
            meta_cnt++; meta_got = meta; meta_len_got = meta_len; meta_cyc = rel;
         end
         if (error) err_cnt++;
         if (abort_at > 0 && !aborted && got_data.size() == abort_at) begin
            reset = 1'b1; aborted = 1; data_full = 1'b0; meta_full = 1'b0;
            continue;
         end
         if (settle > 0) begin
            settle--;
            if (settle == 0) begin
               timed_out = 0;
               break;
            end
         end else if (usb_out_arm && !usb_out_arm_ack) begin
            usb_out_ready = 1'b0; usb_out_arm_ack = 1'b1; arm_seen = 1;
         end else if (usb_out_arm_ack && !usb_out_arm) begin
            usb_out_arm_ack = 1'b0; settle = 3;
         end
         if (rnd_bp) begin
            data_full = data_seen && ($urandom_range(0, 3) == 0);
            meta_full = ($urandom_range(0, 4) == 0);
         end else begin
            if (stall_at > 0 && data_wren && got_data.size() == stall_at) stall_left = stall_cyc;
            data_full = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            if (mfull_cyc > 0 && data_wren && data_last) mfull_left = mfull_cyc;
            meta_full = (mfull_left > 0);
            if (mfull_left > 0) mfull_left--;
         end
         prev_full = data_full;
         prev_addr = usb_out_addr;
      end
      data_full = 1'b0; meta_full = 1'b0; usb_out_ready = 1'b0; usb_out_arm_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; usb_out_ready = 1'b0; usb_out_len = '0; usb_out_arm_ack = 1'b0;
      meta_full = 1'b0; data_full = 1'b0;
      for (int i = 0; i < 512; i++) ep_buf[i] = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checks++;
      if ({meta_wren, data_wren, data_last, error, usb_out_arm} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL reset_strobes: got %b expected 00000",
                  {meta_wren, data_wren, data_last, error, usb_out_arm});
      end
      checks++;
      if ({usb_out_addr, meta, meta_len, data} !== 91'd0) begin
         errors++;
         $display("[TB] FAIL reset_values: got addr=%h meta=%h len=%h data=%h expected all 0",
                  usb_out_addr, meta, meta_len, data);
      end
      reset = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if ({usb_out_arm, data_wren, meta_wren} !== 3'b0) begin
         errors++;
         $display("[TB] FAIL idle_quiet: got %b expected 000", {usb_out_arm, data_wren, meta_wren});
      end
   endtask

   task automatic test_basic();
      for (int i = 0; i < 12; i++) ep_buf[i] = 8'(i + 1);
      run_packet(12, 0, 0, 0, 1'b0, 0);
      build_model(12);
      checks++;
      if (timed_out || !arm_seen) begin
         errors++; $display("[TB] FAIL basic_done: got timeout=%0d arm=%0d expected 0 1", timed_out, arm_seen);
      end
      checks++;
      if (meta_got !== 64'h0102030405060708 || meta_len_got !== 10'd4 || meta_cnt !== 1) begin
         errors++;
         $display("[TB] FAIL basic_meta: got %h/%0d x%0d expected 0102030405060708/4 x1",
                  meta_got, meta_len_got, meta_cnt);
      end
      checks++;
      if (payload_diffs() !== 0) begin
         errors++; $display("[TB] FAIL basic_payload: got %0d diffs expected 0", payload_diffs());
      end
      checks++;
      if (n_last !== 1 || last_idx !== 3) begin
         errors++; $display("[TB] FAIL basic_last: got n=%0d idx=%0d expected n=1 idx=3", n_last, last_idx);
      end
      checks++;
      if ({addr_hist[1], addr_hist[2], addr_hist[3]} !== {9'd0, 9'd1, 9'd2}) begin
         errors++;
         $display("[TB] FAIL basic_first_addr: got %0d %0d %0d expected 0 1 2",
                  addr_hist[1], addr_hist[2], addr_hist[3]);
      end
      checks++;
      if (last_cyc - first_cyc !== 3 || meta_cyc - last_cyc !== 1) begin
         errors++;
         $display("[TB] FAIL basic_timing: got span=%0d meta_gap=%0d expected span=3 meta_gap=1",
                  last_cyc - first_cyc, meta_cyc - last_cyc);
      end
   endtask

   task automatic test_header_only();
      for (int i = 0; i < 8; i++) ep_buf[i] = 8'(8'hA0 + i);
      run_packet(8, 0, 0, 0, 1'b0, 0);
      checks++;
      if (meta_got !== 64'hA0A1A2A3A4A5A6A7 || meta_len_got !== 10'd0 || meta_cnt !== 1) begin
         errors++;
         $display("[TB] FAIL hdr_meta: got %h/%0d x%0d expected A0A1A2A3A4A5A6A7/0 x1",
                  meta_got, meta_len_got, meta_cnt);
      end
      checks++;
      if (got_data.size() !== 0 || max_addr > 7 || timed_out || !arm_seen) begin
         errors++;
         $display("[TB] FAIL hdr_nodata: got bytes=%0d max_addr=%0d timeout=%0d arm=%0d expected 0 <=7 0 1",
                  got_data.size(), max_addr, timed_out, arm_seen);
      end
   endtask

   task automatic test_error();
      int bad_len;
      for (int k = 0; k < 2; k++) begin
         bad_len = (k == 0) ? 5 : int'($urandom_range(513, 1023));
         run_packet(bad_len, 0, 0, 0, 1'b0, 0);
         checks++;
         if (err_cnt !== 1 || got_data.size() !== 0 || meta_cnt !== 0 || !arm_seen || timed_out) begin
            errors++;
            $display("[TB] FAIL drop_len%0d: got err=%0d bytes=%0d metas=%0d arm=%0d timeout=%0d expected 1 0 0 1 0",
                     bad_len, err_cnt, got_data.size(), meta_cnt, arm_seen, timed_out);
         end
      end
      for (int i = 0; i < 12; i++) ep_buf[i] = 8'($urandom);
      run_packet(12, 0, 0, 0, 1'b0, 0);
      build_model(12);
      checks++;
      if ({addr_hist[1], addr_hist[2]} !== {9'd0, 9'd1} || meta_got !== exp_meta || payload_diffs() !== 0) begin
         errors++;
         $display("[TB] FAIL drop_recover: got addr %0d %0d meta=%h diffs=%0d expected 0 1 %h 0",
                  addr_hist[1], addr_hist[2], meta_got, payload_diffs(), exp_meta);
      end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 20; i++) ep_buf[i] = 8'($urandom);
      run_packet(20, 4, 3, 0, 1'b0, 0);
      build_model(20);
      checks++;
      if (got_data.size() !== 12 || payload_diffs() !== 0) begin
         errors++;
         $display("[TB] FAIL stall_payload: got bytes=%0d diffs=%0d expected 12 0", got_data.size(), payload_diffs());
      end
      checks++;
      if (hold_chk !== 3 || hold_viol !== 0) begin
         errors++;
         $display("[TB] FAIL stall_addr_hold: got stalled=%0d moved=%0d expected 3 0", hold_chk, hold_viol);
      end
      checks++;
      if (meta_got !== exp_meta || meta_len_got !== 10'd12 || n_last !== 1 || last_idx !== 11) begin
         errors++;
         $display("[TB] FAIL stall_meta: got %h/%0d last n=%0d idx=%0d expected %h/12 n=1 idx=11",
                  meta_got, meta_len_got, n_last, last_idx, exp_meta);
      end
   endtask

   task automatic test_max_len();
      for (int i = 0; i < 512; i++) ep_buf[i] = 8'(i);
      run_packet(512, 0, 0, 5, 1'b0, 0);
      build_model(512);
      checks++;
      if (got_data.size() !== 504 || payload_diffs() !== 0) begin
         errors++;
         $display("[TB] FAIL max_payload: got bytes=%0d diffs=%0d expected 504 0", got_data.size(), payload_diffs());
      end
      checks++;
      if (max_addr !== 511) begin
         errors++; $display("[TB] FAIL max_last_addr: got %0d expected 511", max_addr);
      end
      checks++;
      if (meta_len_got !== 10'd504 || meta_got !== 64'h0001020304050607 || meta_cnt !== 1) begin
         errors++;
         $display("[TB] FAIL max_meta: got %h/%0d x%0d expected 0001020304050607/504 x1",
                  meta_got, meta_len_got, meta_cnt);
      end
      checks++;
      if (meta_cyc - last_cyc !== 6) begin
         errors++; $display("[TB] FAIL max_meta_delay: got gap=%0d expected 6", meta_cyc - last_cyc);
      end
   endtask

   task automatic test_reset_mid_packet();
      for (int i = 0; i < 40; i++) ep_buf[i] = 8'($urandom);
      run_packet(40, 0, 0, 0, 1'b0, 5);
      build_model(40);
      checks++;
      if (!rst_done || rst_snap !== 96'd0) begin
         errors++; $display("[TB] FAIL midrst_outputs: got done=%0d outs=%h expected 1 0", rst_done, rst_snap);
      end
      checks++;
      if ({addr_hist[1], addr_hist[2], addr_hist[3]} !== {9'd0, 9'd1, 9'd2}) begin
         errors++;
         $display("[TB] FAIL midrst_restart: got %0d %0d %0d expected 0 1 2",
                  addr_hist[1], addr_hist[2], addr_hist[3]);
      end
      checks++;
      if (got_data.size() !== 32 || payload_diffs() !== 0 || meta_cnt !== 1 || meta_got !== exp_meta) begin
         errors++;
         $display("[TB] FAIL midrst_reprocess: got bytes=%0d diffs=%0d metas=%0d meta=%h expected 32 0 1 %h",
                  got_data.size(), payload_diffs(), meta_cnt, meta_got, exp_meta);
      end
   endtask

   task automatic test_random();
      int len;
      for (int p = 0; p < 8; p++) begin
         case (p)
            0:       len = int'($urandom_range(0, 7));
            1:       len = int'($urandom_range(513, 1023));
            default: len = int'($urandom_range(8, 512));
         endcase
         for (int i = 0; i < 512; i++) ep_buf[i] = 8'($urandom);
         run_packet(len, 0, 0, 0, 1'b1, 0);
         build_model(len);
         checks++;
         if (timed_out || !arm_seen) begin
            errors++;
            $display("[TB] FAIL rnd%0d_done: got timeout=%0d arm=%0d expected 0 1", p, timed_out, arm_seen);
         end
         checks++;
         if (err_cnt !== (exp_drop ? 1 : 0) || meta_cnt !== (exp_drop ? 0 : 1)) begin
            errors++;
            $display("[TB] FAIL rnd%0d_len%0d_counts: got err=%0d metas=%0d expected %0d %0d",
                     p, len, err_cnt, meta_cnt, exp_drop ? 1 : 0, exp_drop ? 0 : 1);
         end
         checks++;
         if (payload_diffs() !== 0) begin
            errors++; $display("[TB] FAIL rnd%0d_payload: got %0d diffs expected 0", p, payload_diffs());
         end
         if (!exp_drop) begin
            checks++;
            if (meta_got !== exp_meta || meta_len_got !== exp_meta_len) begin
               errors++;
               $display("[TB] FAIL rnd%0d_meta: got %h/%0d expected %h/%0d",
                        p, meta_got, meta_len_got, exp_meta, exp_meta_len);
            end
            checks++;
            if (n_last !== (exp_data.size() > 0 ? 1 : 0) ||
                (exp_data.size() > 0 && last_idx !== exp_data.size() - 1)) begin
               errors++;
               $display("[TB] FAIL rnd%0d_last: got n=%0d idx=%0d expected idx=%0d",
                        p, n_last, last_idx, exp_data.size() - 1);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_header_only();
      test_error();
      test_backpressure();
      test_max_len();
      test_reset_mid_packet();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
